comparator_serial: RTL

- Sequential N-bit magnitude comparator. Generalises the 1-bit gate-level comparator to parameter WIDTH.
- Compares operands bit-serially, MSB first, one bit per clock, using a 1-bit compare cell.
- Start/done handshake. Optional early exit on the first differing bit.
- Used wherever area matters more than latency, e.g. threshold checks in slow control paths.

---
 rtl/comparator_pkg.sv | 33 +++
 rtl/comparator_bit_cell.sv | 29 ++
 rtl/comparator_serial.sv | 138 +++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared types for the bit-serial magnitude comparator:
//   state_t      - FSM state encoding (IDLE, RUN, DONE)
//   res_t        - compare result encoding (RES_EQ, RES_GT, RES_LT)
//   res_to_flags - maps a result to the {gt, eq, lt} one-hot flag triple
// -----------------------------------------------------------------------------
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } res_t;

    // Returns {gt, eq, lt}; exactly one bit is set for every legal result.
    function automatic logic [2:0] res_to_flags(input res_t r);
        logic [2:0] f;
        case (r)
            RES_GT:  f = 3'b100;
            RES_LT:  f = 3'b001;
            default: f = 3'b010;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/comparator_bit_cell.sv
// -----------------------------------------------------------------------------
// comparator_bit_cell
// Combinational 1-bit magnitude compare cell.
// Ports:
//   a, b    (in)  operand bits
//   invert  (in)  swap the sense of gt/lt (used for a two's-complement sign bit)
//   gt, eq, lt (out) one-hot compare result for this bit
// -----------------------------------------------------------------------------
module comparator_bit_cell (
    input  logic a,
    input  logic b,
    input  logic invert,
    output logic gt,
    output logic eq,
    output logic lt
);

    logic w_gt_raw;
    logic w_lt_raw;

    assign w_gt_raw = a & ~b;
    assign w_lt_raw = ~a & b;

    // A set sign bit means a negative number, so the magnitude sense flips.
    assign gt = invert ? w_lt_raw : w_gt_raw;
    assign lt = invert ? w_gt_raw : w_lt_raw;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/comparator_serial.sv
// -----------------------------------------------------------------------------
// comparator_serial
// Bit-serial N-bit magnitude comparator, MSB first, one bit per clock, with a
// start/done handshake and optional early exit at the first differing bit.
// Optional build macro: COMPARATOR_SIGNED_EN - operands are two's complement
// (the first bit compared, the sign bit, compares with inverted sense).
// Without the macro the compare is purely unsigned.
// Parameters:
//   WIDTH      - operand width (>= 1)
//   EARLY_EXIT - 1: finish on the first differing bit; 0: always scan WIDTH bits
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   start                 - request a compare (sampled only when not busy)
//   a, b                  - operands, captured on an accepted start
//   busy                  - compare in progress
//   done                  - one-cycle pulse, result flags updated this cycle
//   a_gt_b/a_eq_b/a_lt_b  - registered result, held until the next done
// -----------------------------------------------------------------------------
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CNT_W-1:0] r_cnt;
    res_t             r_res;

    logic w_first;
    logic w_invert;
    logic w_gt;
    logic w_eq;
    logic w_lt;
    logic w_diff;
    logic w_finish;
    res_t w_res_next;

    // The counter still holds its load value only while the MSB is evaluated.
    assign w_first = (r_cnt == CNT_TOP);

`ifdef COMPARATOR_SIGNED_EN
    assign w_invert = w_first;
`else
    assign w_invert = 1'b0;
`endif

    comparator_bit_cell u_cell (
        .a      (r_sa[WIDTH-1]),
        .b      (r_sb[WIDTH-1]),
        .invert (w_invert),
        .gt     (w_gt),
        .eq     (w_eq),
        .lt     (w_lt)
    );

    // Only the first difference is recorded; later bits never override it.
    always_comb begin
        w_res_next = r_res;
        if (r_res == RES_EQ) begin
            if (w_gt) begin
                w_res_next = RES_GT;
            end else if (w_lt) begin
                w_res_next = RES_LT;
            end
        end
    end

    assign w_diff   = (r_res == RES_EQ) && !w_eq;
    assign w_finish = ((EARLY_EXIT != 0) && w_diff) || (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_res   <= RES_EQ;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_gt_b  <= 1'b0;
            a_eq_b  <= 1'b0;
            a_lt_b  <= 1'b0;
        end else begin
            case (r_state)
                // IDLE and DONE both accept a new request (back-to-back use).
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_cnt   <= CNT_TOP;
                        r_res   <= RES_EQ;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_res <= w_res_next;
                    if (w_finish) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        {a_gt_b, a_eq_b, a_lt_b} <= res_to_flags(w_res_next);
                        r_state <= DONE;
                    end else begin
                        r_sa  <= r_sa << 1;
                        r_sb  <= r_sb << 1;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
